// File: rtl/run_dump_controller.sv
// Sequences a CPU core through reset hold, bounded execution and a register-file dump
// streamed over a valid/ready interface.
module run_dump_controller #(
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned RESET_CYCLES = 1,
    parameter int unsigned MAX_CYCLES   = 30,
    parameter int unsigned CYCLE_WIDTH  = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic                        except_i,
    input  logic                        halt_req_i,
    output logic                        cpu_reset_o,
    output logic                        cpu_run_o,
    output logic [$clog2(NUM_REGS)-1:0] rf_raddr_o,
    input  logic [DATA_WIDTH-1:0]       rf_rdata_i,
    output logic                        dump_valid_o,
    input  logic                        dump_ready_i,
    output logic [$clog2(NUM_REGS)-1:0] dump_idx_o,
    output logic [DATA_WIDTH-1:0]       dump_data_o,
    output logic                        dump_last_o,
    output logic                        finished_o,
    output logic [1:0]                  cause_o,
    output logic [CYCLE_WIDTH-1:0]      cycle_count_o
);

    localparam int unsigned IdxW  = $clog2(NUM_REGS);
    localparam int unsigned HoldW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [IdxW-1:0]        IdxLast = IdxW'(NUM_REGS - 1);
    localparam logic [HoldW-1:0]       HoldMax = HoldW'(RESET_CYCLES - 1);
    localparam logic [CYCLE_WIDTH-1:0] CycMax  = CYCLE_WIDTH'(MAX_CYCLES - 1);

    localparam logic [1:0] CauseNone    = 2'b00;
    localparam logic [1:0] CauseTimeout = 2'b01;
    localparam logic [1:0] CauseExcept  = 2'b10;
    localparam logic [1:0] CauseHalt    = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRstHold,
        StRun,
        StDump,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [HoldW-1:0]       hold_q, hold_d;
    logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;
    logic [1:0]             cause_q, cause_d;
    logic [IdxW-1:0]        idx_q, idx_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            hold_q  <= '0;
            cycle_q <= '0;
            cause_q <= CauseNone;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cycle_q <= cycle_d;
            cause_q <= cause_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cycle_d = cycle_q;
        cause_d = cause_q;
        idx_d   = idx_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d = StRstHold;
                    hold_d  = '0;
                    cycle_d = '0;
                    cause_d = CauseNone;
                    idx_d   = '0;
                end
            end

            StRstHold: begin
                if (hold_q == HoldMax) begin
                    state_d = StRun;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end

            StRun: begin
                // The edge that leaves RUN still counts as an executed cycle.
                cycle_d = cycle_q + CYCLE_WIDTH'(1);
                if (except_i) begin
                    state_d = StDump;
                    cause_d = CauseExcept;
                    idx_d   = '0;
                end else if (halt_req_i) begin
                    state_d = StDump;
                    cause_d = CauseHalt;
                    idx_d   = '0;
                end else if (cycle_q == CycMax) begin
                    state_d = StDump;
                    cause_d = CauseTimeout;
                    idx_d   = '0;
                end
            end

            StDump: begin
                if (dump_ready_i) begin
                    if (idx_q == IdxLast) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Machine reset stays low in DUMP/DONE so the register file survives readout.
    assign cpu_reset_o   = (state_q == StIdle) || (state_q == StRstHold);
    assign cpu_run_o     = (state_q == StRun);
    assign dump_valid_o  = (state_q == StDump);
    assign finished_o    = (state_q == StDone);
    assign rf_raddr_o    = idx_q;
    assign dump_idx_o    = idx_q;
    assign dump_data_o   = rf_rdata_i;
    assign dump_last_o   = (idx_q == IdxLast);
    assign cause_o       = cause_q;
    assign cycle_count_o = cycle_q;

endmodule

// File: tb/tb_run_dump_controller.sv
// Self-checking bench for run_dump_controller: scenario table plus hand-written reset-abort case,
// dump words checked against a scoreboard queue filled from a register-file model.
module tb_run_dump_controller;

    localparam int NR = 32;
    localparam int DW = 32;
    localparam int RC = 1;
    localparam int MC = 30;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          except_s = 1'b0;
    logic          halt = 1'b0;
    logic          ready = 1'b0;
    logic          cpu_reset, cpu_run, dump_valid, dump_last, finished;
    logic [4:0]    rf_raddr, dump_idx;
    logic [DW-1:0] rf_rdata, dump_data;
    logic [1:0]    cause;
    logic [CW-1:0] cycle_count;

    logic [DW-1:0] rf_mem [NR];
    assign rf_rdata = rf_mem[rf_raddr];

    run_dump_controller #(
        .NUM_REGS    (NR),
        .DATA_WIDTH  (DW),
        .RESET_CYCLES(RC),
        .MAX_CYCLES  (MC),
        .CYCLE_WIDTH (CW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .except_i     (except_s),
        .halt_req_i   (halt),
        .cpu_reset_o  (cpu_reset),
        .cpu_run_o    (cpu_run),
        .rf_raddr_o   (rf_raddr),
        .rf_rdata_i   (rf_rdata),
        .dump_valid_o (dump_valid),
        .dump_ready_i (ready),
        .dump_idx_o   (dump_idx),
        .dump_data_o  (dump_data),
        .dump_last_o  (dump_last),
        .finished_o   (finished),
        .cause_o      (cause),
        .cycle_count_o(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         except_at;
        int         halt_at;
        int         bp;
        int         start_noise;
        int         seed;
        logic [1:0] exp_cause;
        int         exp_cycles;
    } scen_t;

    typedef struct {
        logic [4:0]    idx;
        logic [DW-1:0] data;
    } word_t;

    word_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enter_run(input int seed);
        int rh;
        for (int i = 0; i < NR; i++) rf_mem[i] = DW'(i * 3 + seed);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rsthold_cpu_reset", cpu_reset, 1);
        check("rsthold_cpu_run", cpu_run, 0);
        check("restart_finished", finished, 0);
        check("restart_cause", cause, 0);
        check("restart_cycles", cycle_count, 0);
        rh = 0;
        while (cpu_reset && rh < 20) begin
            tick();
            rh++;
        end
        check("rsthold_len", rh, RC);
    endtask

    task automatic run_scenario(input scen_t s);
        int         k;
        int         c;
        bit         stalled;
        logic [4:0] st_idx;
        logic [DW-1:0] st_data;
        word_t      w;

        enter_run(s.seed);
        k = 0;
        while (cpu_run && k < 200) begin
            k++;
            if (k == 1) check("run_cpu_reset", cpu_reset, 0);
            except_s = (k == s.except_at);
            halt     = (k == s.halt_at);
            start    = (s.start_noise != 0) && (k == 3);
            tick();
        end
        except_s = 1'b0;
        halt     = 1'b0;
        start    = 1'b0;
        check("run_len", k, s.exp_cycles);
        check("stop_cause", cause, s.exp_cause);
        check("stop_cycles", cycle_count, s.exp_cycles);
        check("dump_valid_on_entry", dump_valid, 1);
        check("dump_cpu_reset", cpu_reset, 0);
        check("dump_idx_start", dump_idx, 0);

        for (int i = 0; i < NR; i++) exp_q.push_back('{idx: 5'(i), data: DW'(i * 3 + s.seed)});

        c = 0;
        stalled = 1'b0;
        st_idx = '0;
        st_data = '0;
        while (!finished && c < 1000) begin
            ready = (s.bp != 0) ? (c % 3 == 0) : 1'b1;
            start = (s.start_noise != 0) && (c == 4);
            if (dump_valid) begin
                if (stalled) begin
                    check("stall_idx", dump_idx, st_idx);
                    check("stall_data", dump_data, st_data);
                end
                if (ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_word actual idx=%0d required none", dump_idx);
                    end else begin
                        w = exp_q.pop_front();
                        check("dump_idx", dump_idx, w.idx);
                        check("dump_data", dump_data, w.data);
                        check("dump_last", dump_last, (w.idx == 5'(NR - 1)));
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    st_idx  = dump_idx;
                    st_data = dump_data;
                end
            end
            tick();
            c++;
        end
        start = 1'b0;
        ready = 1'b0;
        check("words_left", exp_q.size(), 0);
        exp_q.delete();
        if (s.bp == 0) check("dump_len", c, NR);
        check("done_finished", finished, 1);
        check("done_valid", dump_valid, 0);
        check("done_cpu_run", cpu_run, 0);
        check("done_cpu_reset", cpu_reset, 0);
        tick();
        check("done_hold_finished", finished, 1);
        check("done_hold_cause", cause, s.exp_cause);
        check("done_hold_cycles", cycle_count, s.exp_cycles);
    endtask

    task automatic reset_mid_dump();
        int k;
        int n;
        enter_run(5);
        k = 0;
        while (cpu_run && k < 200) begin
            tick();
            k++;
        end
        check("abort_run_len", k, MC);
        ready = 1'b1;
        n = 0;
        while (dump_idx != 5'd10 && n < 50) begin
            tick();
            n++;
        end
        check("abort_idx_reached", dump_idx, 10);
        #2;
        rst = 1'b1;
        #1;
        check("abort_valid", dump_valid, 0);
        check("abort_cpu_reset", cpu_reset, 1);
        check("abort_cpu_run", cpu_run, 0);
        check("abort_idx", dump_idx, 0);
        check("abort_cause", cause, 0);
        check("abort_cycles", cycle_count, 0);
        check("abort_finished", finished, 0);
        ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("abort_idle_reset", cpu_reset, 1);
        check("abort_idle_valid", dump_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        scen_t tbl[8];
        tbl[0] = '{0,  0,  0, 0, 0,  2'b01, 30};
        tbl[1] = '{5,  0,  0, 0, 0,  2'b10, 5};
        tbl[2] = '{7,  7,  1, 0, 11, 2'b10, 7};
        tbl[3] = '{30, 30, 0, 0, 2,  2'b10, 30};
        tbl[4] = '{0,  12, 1, 1, 9,  2'b11, 12};
        tbl[5] = '{0,  30, 0, 0, 4,  2'b11, 30};
        tbl[6] = '{1,  0,  0, 1, 6,  2'b10, 1};
        tbl[7] = '{0,  0,  1, 1, 77, 2'b01, 30};

        for (int i = 0; i < NR; i++) rf_mem[i] = '0;
        tick();
        tick();
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_cpu_run", cpu_run, 0);
        check("rst_valid", dump_valid, 0);
        check("rst_idx", dump_idx, 0);
        check("rst_finished", finished, 0);
        check("rst_cause", cause, 0);
        check("rst_cycles", cycle_count, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            except_s = 1'b1;
            halt = 1'b1;
            tick();
            check("idle_cpu_reset", cpu_reset, 1);
            check("idle_cpu_run", cpu_run, 0);
        end
        except_s = 1'b0;
        halt = 1'b0;

        for (int i = 0; i < 8; i++) run_scenario(tbl[i]);
        reset_mid_dump();
        run_scenario(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
